// File: rtl/e2g_pkg.sv
// Shared defaults and types for the e2g_buffer decode-side gearbox.
// Defining E2G_FLUSH_EN adds the flush port and the RUN/FLUSH state machine.
package e2g_pkg;

  localparam int E2G_IN_W     = 11;
  localparam int E2G_OUT_W    = 8;
  localparam int E2G_BUF_SIZE = 24;

  function automatic int level_w(input int size);
    return $clog2(size + 1);
  endfunction

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/e2g_buffer.sv
// Bit-level gearbox repacking IN_DATA_WIDTH-bit words into OUT_DATA_WIDTH-bit words, LSB-first.
// Optional macro E2G_FLUSH_EN: adds the flush input that emits a zero-padded partial residue.
module e2g_buffer
  import e2g_pkg::*;
#(
  parameter int IN_DATA_WIDTH   = E2G_IN_W,
  parameter int OUT_DATA_WIDTH  = E2G_OUT_W,
  parameter int BUF_BUFFER_SIZE = E2G_BUF_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IN_DATA_WIDTH-1:0]              in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_DATA_WIDTH-1:0]             out_data,
  output logic [level_w(BUF_BUFFER_SIZE)-1:0]   level
`ifdef E2G_FLUSH_EN
  ,
  input  logic                                  flush
`endif
);

  localparam int LEVEL_W = level_w(BUF_BUFFER_SIZE);
  localparam int LW_EXT  = LEVEL_W + 1;

  localparam logic [LW_EXT-1:0] IN_L  = LW_EXT'(IN_DATA_WIDTH);
  localparam logic [LW_EXT-1:0] OUT_L = LW_EXT'(OUT_DATA_WIDTH);
  localparam logic [LW_EXT-1:0] BUF_L = LW_EXT'(BUF_BUFFER_SIZE);

  if (BUF_BUFFER_SIZE < IN_DATA_WIDTH + OUT_DATA_WIDTH - 1) begin : g_size_chk
    $error("e2g_buffer: BUF_BUFFER_SIZE too small for IN_DATA_WIDTH+OUT_DATA_WIDTH-1");
  end

  logic [BUF_BUFFER_SIZE-1:0] store_q, store_d;
  logic [LW_EXT-1:0]          level_q, level_d;
  state_t                     state_q, state_d;

  logic                       acc, pop;
  logic [BUF_BUFFER_SIZE-1:0] shifted, ins;
  logic [LW_EXT-1:0]          base;

  // Handshake flags depend only on registered state, never on out_ready.
  assign in_ready  = (level_q + IN_L <= BUF_L) && (state_q == RUN);
  assign out_valid = (state_q == FLUSH) || (level_q >= OUT_L);
  assign out_data  = store_q[OUT_DATA_WIDTH-1:0];
  assign level     = level_q[LEVEL_W-1:0];

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  always_comb begin
    store_d = store_q;
    level_d = level_q;
    state_d = state_q;
    shifted = pop ? (store_q >> OUT_DATA_WIDTH) : store_q;
    base    = pop ? (level_q - OUT_L) : level_q;
    ins     = '0;
    ins[IN_DATA_WIDTH-1:0] = in_data;
    ins     = ins << base;

    if (state_q == FLUSH) begin
      // Residue is already zero-padded since bits above level are always 0.
      if (pop) begin
        store_d = '0;
        level_d = '0;
        state_d = RUN;
      end
    end else begin
      store_d = acc ? (shifted | ins) : shifted;
      level_d = acc ? (base + IN_L) : base;
`ifdef E2G_FLUSH_EN
      if (flush && !acc && !pop && (level_q != '0) && (level_q < OUT_L)) begin
        state_d = FLUSH;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q <= '0;
      level_q <= '0;
      state_q <= RUN;
    end else begin
      store_q <= store_d;
      level_q <= level_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (level_q <= BUF_L);
    end
  end

endmodule
